// File: rtl/sti_tx_scheduler_if.sv
// sti_tx_scheduler_if: bundles the requester-side and STI-side signals of the
// scheduler.
//   req/req_data/req_msb/req_low : requester transfer requests and payloads
//   ack/grant_id                 : completion pulse and current owner index
//   sti_load/sti_data/sti_msb/sti_low : STI parallel-load inputs
//   sti_so_valid                 : STI serial-output valid, monitored in SHIFT
// Modports:
//   master : requesters plus the STI, i.e. everything around the scheduler
//   slave  : the scheduler itself
interface sti_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]    req_msb;
  logic [NREQ-1:0]    req_low;
  logic [NREQ-1:0]    ack;
  logic [IDW-1:0]     grant_id;
  logic               sti_load;
  logic [15:0]        sti_data;
  logic               sti_msb;
  logic               sti_low;
  logic               sti_so_valid;

  modport master (
    output req, req_data, req_msb, req_low, sti_so_valid,
    input  ack, grant_id, sti_load, sti_data, sti_msb, sti_low
  );

  modport slave (
    input  req, req_data, req_msb, req_low, sti_so_valid,
    output ack, grant_id, sti_load, sti_data, sti_msb, sti_low
  );
endinterface

// File: rtl/sti_tx_scheduler.sv
// sti_tx_scheduler: round-robin scheduler sharing one STI parallel-to-serial
// transmitter between NREQ requesters. The winner's word and mode are latched,
// presented to the STI with a one-cycle load strobe, held for the 8/16-bit
// shift and an optional gap, and the owner is acknowledged on the last bit.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   bus       : sti_tx_scheduler_if.slave (requests, ack, grant_id, STI side)
//   i_err_clr : clears o_err (a simultaneous new error wins)
//   o_busy    : high in any state other than IDLE
//   o_err     : sticky, set when so_valid is low during SHIFT
module sti_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int GAP_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  sti_tx_scheduler_if.slave  bus,
  input  logic               i_err_clr,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam int unsigned NREQ_U   = NREQ;
  localparam logic [3:0]  GAP_LAST = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_bit_cnt;
  logic [3:0]      r_gap_cnt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic [15:0]     r_sti_data;
  logic            r_sti_msb;
  logic            r_sti_low;
  logic            r_err;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [15:0]     w_sel_data;
  logic            w_sel_msb;
  logic            w_sel_low;
  logic [3:0]      w_len_last;
  logic            w_shift_done;
  logic            w_gap_done;
  logic [NREQ-1:0] w_ack;

  // Round-robin search starting just after the last owner; the first set
  // request in rr_ptr+1 .. rr_ptr+NREQ (mod NREQ) wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_data = '0;
    w_sel_msb  = 1'b0;
    w_sel_low  = 1'b0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      idx = (32'(r_rr_ptr) + k) % NREQ_U;
      if (!w_found && bus.req[idx]) begin
        w_found    = 1'b1;
        w_winner   = idx[IDW-1:0];
        w_sel_data = bus.req_data[16*idx +: 16];
        w_sel_msb  = bus.req_msb[idx];
        w_sel_low  = bus.req_low[idx];
      end
    end
  end

  assign w_len_last   = r_sti_low ? 4'd15 : 4'd7;
  assign w_shift_done = (r_bit_cnt == w_len_last);
  assign w_gap_done   = (r_gap_cnt == GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_grant_id <= '0;
      r_sti_data <= '0;
      r_sti_msb  <= 1'b0;
      r_sti_low  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_sti_data <= w_sel_data;
            r_sti_msb  <= w_sel_msb;
            r_sti_low  <= w_sel_low;
          end
        end
        S_LOAD: r_bit_cnt <= '0;
        S_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (w_shift_done) begin
            r_rr_ptr  <= r_grant_id;
            r_gap_cnt <= '0;
          end
        end
        S_GAP: r_gap_cnt <= r_gap_cnt + 4'd1;
        default: ;
      endcase
      // Set has priority over clear.
      if (r_state == S_SHIFT && !bus.sti_so_valid) r_err <= 1'b1;
      else if (i_err_clr)                           r_err <= 1'b0;
    end
  end

  // Moore decode of the completion pulse on the last shift cycle.
  always_comb begin
    w_ack = '0;
    if (r_state == S_SHIFT && w_shift_done) w_ack[r_grant_id] = 1'b1;
  end

  assign bus.ack      = w_ack;
  assign bus.grant_id = r_grant_id;
  assign bus.sti_load = (r_state == S_LOAD);
  assign bus.sti_data = r_sti_data;
  assign bus.sti_msb  = r_sti_msb;
  assign bus.sti_low  = r_sti_low;
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;

endmodule
